// File: rtl/mem_arbiter_2to1_if.sv
// Mem_ift: memory port with independent read and write request/reply channels.
interface Mem_ift #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic                  r_request_valid;
  logic                  r_request_ready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  r_reply_valid;
  logic                  r_reply_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  logic                  w_request_valid;
  logic                  w_request_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [StrbW-1:0]      wstrb;
  logic                  w_reply_valid;
  logic                  w_reply_ready;
  logic [1:0]            bresp;

  modport Master (
    output r_request_valid, raddr, r_reply_ready,
    input  r_request_ready, r_reply_valid, rdata, rresp,
    output w_request_valid, waddr, wdata, wstrb, w_reply_ready,
    input  w_request_ready, w_reply_valid, bresp
  );

  modport Slave (
    input  r_request_valid, raddr, r_reply_ready,
    output r_request_ready, r_reply_valid, rdata, rresp,
    input  w_request_valid, waddr, wdata, wstrb, w_reply_ready,
    output w_request_ready, w_reply_valid, bresp
  );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// Two-requester to one-slave Mem_ift arbiter; read and write channels arbitrate independently.
// Define MEM_ARB_FIXED_PRIORITY_EN to make master0 always win contention (default round-robin).

// One channel: grant FSM with one outstanding transaction and reply routing by owner.
module mem_arb_chan (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_valid_i,
  output logic [1:0] req_ready_c,
  output logic       slv_req_valid_c,
  input  logic       slv_req_ready_i,
  input  logic       slv_rep_valid_i,
  output logic       slv_rep_ready_c,
  output logic [1:0] rep_valid_c,
  input  logic [1:0] rep_ready_i,
  output logic       route_c
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_REPLY} state_e;

  state_e state_q, state_d;
  logic   own_q, own_d;
  logic   prio_q, prio_d;
  logic   sel_c, has_c;

  // Prefer the priority holder, fall back to the other requester.
  always_comb begin
    sel_c = prio_q;
    has_c = 1'b1;
    if (!req_valid_i[prio_q]) begin
      sel_c = ~prio_q;
      has_c = req_valid_i[~prio_q];
    end
  end

  always_comb begin
    state_d         = state_q;
    own_d           = own_q;
    prio_d          = prio_q;
    route_c         = own_q;
    slv_req_valid_c = 1'b0;
    req_ready_c     = '0;
    slv_rep_ready_c = 1'b0;
    rep_valid_c     = '0;
    case (state_q)
      IDLE: begin
        route_c            = sel_c;
        slv_req_valid_c    = has_c;
        req_ready_c[sel_c] = has_c & slv_req_ready_i;
        if (has_c) begin
          own_d   = sel_c;
          state_d = slv_req_ready_i ? WAIT_REPLY : REQ;
        end
      end
      REQ: begin
        slv_req_valid_c    = req_valid_i[own_q];
        req_ready_c[own_q] = slv_req_ready_i;
        if (req_valid_i[own_q] && slv_req_ready_i) state_d = WAIT_REPLY;
      end
      WAIT_REPLY: begin
        rep_valid_c[own_q] = slv_rep_valid_i;
        slv_rep_ready_c    = rep_ready_i[own_q];
        if (slv_rep_valid_i && rep_ready_i[own_q]) begin
          state_d = IDLE;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
          prio_d  = 1'b0;
`else
          prio_d  = ~own_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs stay low for the whole reset assertion.
    if (!rstn) begin
      slv_req_valid_c = 1'b0;
      req_ready_c     = '0;
      slv_rep_ready_c = 1'b0;
      rep_valid_c     = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      prio_q  <= prio_d;
    end
  end

  a_reply_only_when_waiting: assert property (@(posedge clk) disable iff (!rstn)
    slv_rep_valid_i |-> (state_q == WAIT_REPLY));
endmodule

module mem_arbiter_2to1 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input logic   clk,
  input logic   rstn,
  Mem_ift.Slave  master0,
  Mem_ift.Slave  master1,
  Mem_ift.Master slave0
);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic                  r_route_c, w_route_c;
  logic [1:0]            r_req_ready_c, r_rep_valid_c;
  logic [1:0]            w_req_ready_c, w_rep_valid_c;
  logic [ADDR_WIDTH-1:0] raddr_c, waddr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [StrbW-1:0]      wstrb_c;

  mem_arb_chan u_r_chan (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid_i     ({master1.r_request_valid, master0.r_request_valid}),
    .req_ready_c     (r_req_ready_c),
    .slv_req_valid_c (slave0.r_request_valid),
    .slv_req_ready_i (slave0.r_request_ready),
    .slv_rep_valid_i (slave0.r_reply_valid),
    .slv_rep_ready_c (slave0.r_reply_ready),
    .rep_valid_c     (r_rep_valid_c),
    .rep_ready_i     ({master1.r_reply_ready, master0.r_reply_ready}),
    .route_c         (r_route_c)
  );

  mem_arb_chan u_w_chan (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid_i     ({master1.w_request_valid, master0.w_request_valid}),
    .req_ready_c     (w_req_ready_c),
    .slv_req_valid_c (slave0.w_request_valid),
    .slv_req_ready_i (slave0.w_request_ready),
    .slv_rep_valid_i (slave0.w_reply_valid),
    .slv_rep_ready_c (slave0.w_reply_ready),
    .rep_valid_c     (w_rep_valid_c),
    .rep_ready_i     ({master1.w_reply_ready, master0.w_reply_ready}),
    .route_c         (w_route_c)
  );

  // Request payload follows the granted master; reply payload is broadcast, qualified by valid.
  assign raddr_c = r_route_c ? master1.raddr : master0.raddr;
  assign waddr_c = w_route_c ? master1.waddr : master0.waddr;
  assign wdata_c = w_route_c ? master1.wdata : master0.wdata;
  assign wstrb_c = w_route_c ? master1.wstrb : master0.wstrb;

  assign slave0.raddr = raddr_c;
  assign slave0.waddr = waddr_c;
  assign slave0.wdata = wdata_c;
  assign slave0.wstrb = wstrb_c;

  assign master0.r_request_ready = r_req_ready_c[0];
  assign master1.r_request_ready = r_req_ready_c[1];
  assign master0.r_reply_valid   = r_rep_valid_c[0];
  assign master1.r_reply_valid   = r_rep_valid_c[1];
  assign master0.rdata           = slave0.rdata;
  assign master1.rdata           = slave0.rdata;
  assign master0.rresp           = slave0.rresp;
  assign master1.rresp           = slave0.rresp;

  assign master0.w_request_ready = w_req_ready_c[0];
  assign master1.w_request_ready = w_req_ready_c[1];
  assign master0.w_reply_valid   = w_rep_valid_c[0];
  assign master1.w_reply_valid   = w_rep_valid_c[1];
  assign master0.bresp           = slave0.bresp;
  assign master1.bresp           = slave0.bresp;
endmodule
